spi_master_shifter: RTL and testbench
=====================================

SPI_MASTER_SHIFTER -- requirements
Module: spi_master_shifter

Interface
REQ-001 Parameter DATA_W, default 8, frame length in bits.
REQ-002 Parameter CS_W, default 4, number of chip selects.
REQ-003 Parameter DIV_W, default 8, width of the clock divider field.
REQ-004 clk_i  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 rst_n_i  input  1  reset, synchronous and active-low.
REQ-006 req_valid_i  input  1  transfer request valid.
REQ-007 req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-008 req_data_i  input  DATA_W  byte to transmit, MSB first.
REQ-009 req_cs_i  input  $clog2(CS_W)  index of the slave to select.
REQ-010 clk_div_i  input  DIV_W  half-period H = clk_div_i+1 system cycles.
REQ-011 rsp_valid_o  output  1  one-cycle pulse when received data is valid.
REQ-012 rsp_data_o  output  DATA_W  byte captured from MISO; holds its value until the next rsp_valid_o.
REQ-013 busy_o  output  1  high in any state other than IDLE.
REQ-014 spi_clk_o  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-015 spi_mosi_o  output  1  master out, slave in.
REQ-016 spi_miso_i  input  1  master in, slave out; a high-Z value is sampled as-is, with no filtering.
REQ-017 spi_csn_o  output  CS_W  one-hot active-low chip selects.
REQ-018 xfer_count_o  output  16  completed-transfer count; present only when SPI_MASTER_XFER_CNT_EN is defined.

Function
REQ-019 FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-020 req_ready_o is high only in IDLE.
REQ-021 On acceptance, latch req_data_i, req_cs_i and clk_div_i, then move to SETUP.
REQ-022 Input changes after acceptance have no effect on the transfer in progress.
REQ-023 SETUP: drive spi_csn_o[cs]=0, drive spi_mosi_o with the MSB and hold spi_clk_o=0 for H cycles, then move to SHIFT.
REQ-024 SHIFT: toggle spi_clk_o every H cycles for 2*DATA_W half-periods.
REQ-025 On each rising spi_clk_o, shift the sampled spi_miso_i into the RX register LSB.
REQ-026 On each falling spi_clk_o except the last, advance spi_mosi_o to the next bit.
REQ-027 After the last falling edge, move to HOLD: spi_clk_o=0 and CS still asserted for H cycles.
REQ-028 DONE (1 cycle): all spi_csn_o high, rsp_valid_o=1, rsp_data_o=RX register; then return to IDLE.
REQ-029 Latency from the acceptance edge to the rsp_valid_o cycle is exactly 1+(2*DATA_W+2)*H cycles; 19 cycles for DATA_W=8, div=0.
REQ-030 Back-to-back: a request accepted in the IDLE cycle after DONE leaves CS high for at least 2 system cycles between frames.
REQ-031 A req_cs_i value >= CS_W selects no chip select (all high), but the frame still runs and completes.
REQ-032 The half-period counter uses DIV_W bits; clk_div_i=all-ones gives H=2^DIV_W with no overflow.
REQ-033 Outside SETUP/SHIFT/HOLD: spi_clk_o=0, spi_mosi_o=0, spi_csn_o all ones.

Reset
REQ-034 When rst_n_i=0 at a clock edge: state=IDLE, spi_csn_o all ones, spi_clk_o=0, spi_mosi_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0, xfer_count_o=0.
REQ-035 Reset mid-transfer aborts the frame with no rsp_valid_o pulse and no count increment.

Configuration
REQ-036 With SPI_MASTER_XFER_CNT_EN defined, xfer_count_o increments by one in each DONE cycle and wraps 0xFFFF->0x0000.
REQ-037 Without SPI_MASTER_XFER_CNT_EN, the xfer_count_o port and the counter are absent and behaviour is otherwise identical.

Structure
REQ-038 Package spi_master_pkg holds the FSM state enum and the default constants DATA_W, CS_W and DIV_W.
REQ-039 Sub-module spi_clk_div generates the half-period tick from the latched divider and is cleared on leaving IDLE.

Verification
REQ-040 div=0, data=0xA5, cs=0, MOSI looped to MISO -> csn=4'b1110 during the frame, 8 spi_clk pulses, rsp_data=0xA5 in cycle 19.
REQ-041 div=1, data=0x3C, cs=2, MISO from a mode-0 slave returning 0x96 -> spi_clk period 4 cycles, csn=4'b1011, rsp_data=0x96 in cycle 37.
REQ-042 Two back-to-back requests 0x01 then 0x80 -> req_ready low while busy, CS high for >=2 cycles between frames, two rsp pulses.
REQ-043 rst_n_i low for 1 cycle during bit 4 -> csn=4'hF, spi_clk=0 on the next cycle, no rsp_valid, count unchanged.
REQ-044 Counter build, 0xFFFF preloaded via 65535 transfers (or forced) plus 1 transfer -> xfer_count_o=0x0000.
REQ-045 req_cs_i=3 with CS_W=3 -> spi_csn_o stays all ones, rsp_valid still pulses after 19 cycles at div=0.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared FSM state type and default sizing for the SPI master shifter.
package spi_master_pkg;

    localparam int unsigned SPI_DATA_W = 8;
    localparam int unsigned SPI_CS_W   = 4;
    localparam int unsigned SPI_DIV_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses once every div_i+1 cycles while not cleared.
module spi_clk_div
    import spi_master_pkg::*;
#(
    parameter int unsigned DIV_W = SPI_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    // Compare-then-restart keeps the all-ones divider at 2^DIV_W cycles without a wider counter.
    assign tick_o = !clear_i && (cnt_q == div_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master: one MSB-first frame per accepted request on a one-hot active-low chip select.
// Define SPI_MASTER_XFER_CNT_EN to add the 16-bit completed-transfer counter xfer_count_o.
module spi_master_shifter
    import spi_master_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W,
    parameter int unsigned CS_W   = SPI_CS_W,
    parameter int unsigned DIV_W  = SPI_DIV_W,
    localparam int unsigned CS_IDX_W = (CS_W > 1) ? $clog2(CS_W) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [CS_IDX_W-1:0] req_cs_i,
    input  logic [DIV_W-1:0]    clk_div_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_data_o,
`ifdef SPI_MASTER_XFER_CNT_EN
    output logic [15:0]         xfer_count_o,
`endif
    output logic                busy_o,
    output logic                spi_clk_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i,
    output logic [CS_W-1:0]     spi_csn_o
);

    localparam int unsigned EDGES  = 2 * DATA_W;
    localparam int unsigned EDGE_W = $clog2(EDGES);

    spi_state_e        state_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DIV_W-1:0]  div_q;
    logic [EDGE_W-1:0] edge_q;
    logic [CS_W-1:0]   csn_sel;
    logic              tick;
    logic              div_clear;

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign div_clear   = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Out-of-range indices match no bit, leaving every select deasserted.
    always_comb begin
        csn_sel = '1;
        for (int unsigned i = 0; i < CS_W; i++) begin
            if (32'(req_cs_i) == i) begin
                csn_sel[i] = 1'b0;
            end
        end
    end

    spi_clk_div #(
        .DIV_W(DIV_W)
    ) u_clk_div (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (div_clear),
        .div_i   (div_q),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            div_q       <= '0;
            edge_q      <= '0;
            spi_clk_o   <= 1'b0;
            spi_mosi_o  <= 1'b0;
            spi_csn_o   <= '1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        tx_q       <= req_data_i;
                        div_q      <= clk_div_i;
                        edge_q     <= '0;
                        spi_csn_o  <= csn_sel;
                        spi_mosi_o <= req_data_i[DATA_W-1];
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        edge_q <= edge_q + 1'b1;
                        if (!spi_clk_o) begin
                            spi_clk_o <= 1'b1;
                            rx_q      <= {rx_q[DATA_W-2:0], spi_miso_i};
                        end else begin
                            spi_clk_o <= 1'b0;
                            if (edge_q == EDGE_W'(EDGES - 1)) begin
                                state_q <= ST_HOLD;
                            end else begin
                                spi_mosi_o <= tx_q[DATA_W-2];
                                tx_q       <= {tx_q[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        spi_csn_o   <= '1;
                        spi_mosi_o  <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= rx_q;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_XFER_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            xfer_count_o <= '0;
        end else if (state_q == ST_DONE) begin
            xfer_count_o <= xfer_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: frame-level timing model plus directed vectors.
// Define SPI_MASTER_XFER_CNT_EN to also check xfer_count_o.
`timescale 1ns/1ps
module tb_spi_master_shifter;

    localparam int unsigned DW  = 8;
    localparam int unsigned CSW = 4;
    localparam int unsigned DVW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [DW-1:0]  req_data = '0;
    logic [1:0]     req_cs = '0;
    logic [DVW-1:0] clk_div = '0;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_data;
    logic           busy;
    logic           spi_clk;
    logic           spi_mosi;
    logic           spi_miso;
    logic [CSW-1:0] spi_csn;
`ifdef SPI_MASTER_XFER_CNT_EN
    logic [15:0]    xfer_count;
    logic [15:0]    xfer_count3;
`endif

    logic           req_valid3 = 1'b0;
    logic           req_ready3;
    logic [1:0]     req_cs3 = 2'd3;
    logic [DW-1:0]  req_data3 = 8'h33;
    logic [DVW-1:0] clk_div3 = '0;
    logic           rsp_valid3;
    logic [DW-1:0]  rsp_data3;
    logic           busy3;
    logic           spi_clk3;
    logic           spi_mosi3;
    logic           spi_miso3 = 1'b0;
    logic [2:0]     spi_csn3;

    always #5 clk = ~clk;

    spi_master_shifter #(.DATA_W(DW), .CS_W(CSW), .DIV_W(DVW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data_i   (req_data),
        .req_cs_i     (req_cs),
        .clk_div_i    (clk_div),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
`ifdef SPI_MASTER_XFER_CNT_EN
        .xfer_count_o (xfer_count),
`endif
        .busy_o       (busy),
        .spi_clk_o    (spi_clk),
        .spi_mosi_o   (spi_mosi),
        .spi_miso_i   (spi_miso),
        .spi_csn_o    (spi_csn)
    );

    spi_master_shifter #(.DATA_W(DW), .CS_W(3), .DIV_W(DVW)) dut3 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid3),
        .req_ready_o  (req_ready3),
        .req_data_i   (req_data3),
        .req_cs_i     (req_cs3),
        .clk_div_i    (clk_div3),
        .rsp_valid_o  (rsp_valid3),
        .rsp_data_o   (rsp_data3),
`ifdef SPI_MASTER_XFER_CNT_EN
        .xfer_count_o (xfer_count3),
`endif
        .busy_o       (busy3),
        .spi_clk_o    (spi_clk3),
        .spi_mosi_o   (spi_mosi3),
        .spi_miso_i   (spi_miso3),
        .spi_csn_o    (spi_csn3)
    );

    // Slave side: either loop MOSI back, or a mode-0 slave shifting slv_word out on falling SCLK.
    logic          loopback = 1'b1;
    logic [DW-1:0] slv_word = '0;
    int unsigned   slv_idx = 0;
    wire           cs_idle = &spi_csn;

    initial begin
        logic clk_prev;
        clk_prev = 1'b0;
        forever begin
            @(spi_clk or cs_idle);
            if (cs_idle) slv_idx = 0;
            else if (clk_prev && !spi_clk) slv_idx = slv_idx + 1;
            clk_prev = spi_clk;
        end
    end

    assign spi_miso = loopback ? spi_mosi : ((slv_idx < DW) ? slv_word[DW-1-slv_idx] : 1'b0);

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: one accepted request occupies (2*DW+2)*H cycles followed by one DONE cycle.
    int unsigned   cyc = 0;
    bit            m_busy = 1'b0;
    int unsigned   m_k = 0, m_H = 1, m_T = 0, m_acc_cyc = 0, n_acc = 0;
    logic [DW-1:0] m_data = '0, m_rx = '0, m_last = '0;
    logic [CSW-1:0] m_csn = '1;
    logic [15:0]   m_count = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_last  = '0;
            m_count = '0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy    = 1'b1;
                m_k       = 0;
                m_H       = 32'(clk_div) + 1;
                m_T       = (2 * DW + 2) * m_H;
                m_data    = req_data;
                m_csn     = '1;
                m_csn[req_cs] = 1'b0;
                m_rx      = loopback ? req_data : slv_word;
                m_acc_cyc = cyc;
                n_acc++;
            end
        end else if (m_k == m_T) begin
            m_busy = 1'b0;
            m_count++;
        end else begin
            m_k++;
            if (m_k == m_T) m_last = m_rx;
        end
        cyc++;
    end

    bit            chk_en = 1'b0;
    int unsigned   rsp_cnt = 0, rsp_cyc = 0;
    logic [DW-1:0] rsp_val = '0;

    always @(negedge clk) begin
        logic           e_clk, e_mosi, e_rv, e_busy, e_rdy;
        logic [CSW-1:0] e_csn;
        int unsigned    h;
        if (chk_en) begin
            e_clk = 1'b0; e_mosi = 1'b0; e_rv = 1'b0; e_busy = 1'b0; e_rdy = 1'b1; e_csn = '1;
            if (m_busy) begin
                e_busy = 1'b1;
                e_rdy  = 1'b0;
                if (m_k < m_T) begin
                    e_csn = m_csn;
                    if (m_k < m_H) begin
                        e_mosi = m_data[DW-1];
                    end else if (m_k < m_H * (2 * DW + 1)) begin
                        h      = (m_k - m_H) / m_H;
                        e_clk  = ((h % 2) == 1);
                        e_mosi = m_data[DW-1-h/2];
                    end else begin
                        e_mosi = m_data[0];
                    end
                end else begin
                    e_rv = 1'b1;
                end
            end
            check("spi_clk", 32'(spi_clk), 32'(e_clk));
            check("spi_mosi", 32'(spi_mosi), 32'(e_mosi));
            check("spi_csn", 32'(spi_csn), 32'(e_csn));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("rsp_data", 32'(rsp_data), 32'(m_last));
            check("busy", 32'(busy), 32'(e_busy));
            check("req_ready", 32'(req_ready), 32'(e_rdy));
`ifdef SPI_MASTER_XFER_CNT_EN
            check("xfer_count", 32'(xfer_count), 32'(m_count));
`endif
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                rsp_val = rsp_data;
            end
        end
    end

    int unsigned pulse_cnt = 0, rise_cyc = 0, rise_prev = 0;
    always @(posedge spi_clk) begin
        pulse_cnt++;
        rise_prev = rise_cyc;
        rise_cyc  = cyc;
    end

    task automatic wait_acc(input int unsigned prev);
        for (int i = 0; i < 2000 && n_acc == prev; i++) @(negedge clk);
        if (n_acc == prev) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got %0d accepts, expected %0d", n_acc, prev + 1);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10000 && m_busy; i++) @(negedge clk);
        @(negedge clk);
        if (m_busy) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: got busy, expected idle");
        end
    endtask

    // Issue one request, then scramble the inputs so any use after acceptance shows up.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] cs, input logic [DVW-1:0] div);
        int unsigned p;
        p = n_acc;
        @(negedge clk);
        req_data = d; req_cs = cs; clk_div = div; req_valid = 1'b1;
        wait_acc(p);
        req_valid = 1'b0;
        req_data  = ~d;
        req_cs    = cs + 2'd1;
        clk_div   = div ^ 8'h5A;
    endtask

    initial begin
        int unsigned p0, r0, p, gap, a3, lat3;
        bit          all_hi, found;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_csn", 32'(spi_csn), 32'h0000_000F);
        check("reset_rsp_data", 32'(rsp_data), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // div=0, 0xA5 on cs0 with MOSI looped back.
        loopback = 1'b1;
        p0 = pulse_cnt; r0 = rsp_cnt;
        send(8'hA5, 2'd0, 8'd0);
        repeat (4) @(negedge clk);
        check("a5_csn_mid", 32'(spi_csn), 32'h0000_000E);
        wait_idle();
        check("a5_pulses", pulse_cnt - p0, 32'd8);
        check("a5_latency", rsp_cyc - m_acc_cyc, 32'd19);
        check("a5_rsp", 32'(rsp_val), 32'h0000_00A5);
        check("a5_rsp_count", rsp_cnt - r0, 32'd1);

        // div=1, 0x3C on cs2 against a slave returning 0x96.
        loopback = 1'b0;
        slv_word = 8'h96;
        send(8'h3C, 2'd2, 8'd1);
        repeat (6) @(negedge clk);
        check("96_csn_mid", 32'(spi_csn), 32'h0000_000B);
        wait_idle();
        check("96_rsp", 32'(rsp_val), 32'h0000_0096);
        check("96_latency", rsp_cyc - m_acc_cyc, 32'd37);
        check("96_sclk_period", rise_cyc - rise_prev, 32'd4);
        loopback = 1'b1;

        // Back-to-back 0x01 then 0x80 with req_valid held.
        r0 = rsp_cnt; p = n_acc;
        @(negedge clk);
        req_data = 8'h01; req_cs = 2'd1; clk_div = 8'd0; req_valid = 1'b1;
        wait_acc(p);
        req_data = 8'h80;
        repeat (5) @(negedge clk);
        check("b2b_ready_low", 32'(req_ready), 32'h0);
        for (int i = 0; i < 100 && spi_csn != 4'hF; i++) @(negedge clk);
        gap = 0;
        for (int i = 0; i < 100 && spi_csn == 4'hF; i++) begin
            gap++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_cs_gap_ge2", 32'(gap >= 2), 32'd1);
        check("b2b_accepts", n_acc - p, 32'd2);
        wait_idle();
        check("b2b_rsp_count", rsp_cnt - r0, 32'd2);
        check("b2b_last_rsp", 32'(rsp_val), 32'h0000_0080);

        // Reset asserted for one cycle while bit 4 is on the wire.
        send(8'h5A, 2'd3, 8'd0);
        repeat (8) @(negedge clk);
        r0 = rsp_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_csn", 32'(spi_csn), 32'h0000_000F);
        check("abort_sclk", 32'(spi_clk), 32'h0);
        repeat (30) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - r0, 32'd0);
        check("abort_rsp_data", 32'(rsp_data), 32'h0);

        // All-ones divider: H = 256.
        send(8'hC3, 2'd1, 8'hFF);
        wait_idle();
        check("div_max_latency", rsp_cyc - m_acc_cyc, 32'd4609);
        check("div_max_rsp", 32'(rsp_val), 32'h0000_00C3);

        // CS_W=3 instance with out-of-range select 3.
        @(negedge clk);
        req_valid3 = 1'b1;
        a3 = cyc;
        @(negedge clk);
        req_valid3 = 1'b0;
        all_hi = 1'b1; found = 1'b0; lat3 = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (spi_csn3 != 3'b111) all_hi = 1'b0;
            if (rsp_valid3) begin
                found = 1'b1;
                lat3  = cyc - a3;
            end else begin
                @(negedge clk);
            end
        end
        check("cs3_all_high", 32'(all_hi), 32'd1);
        check("cs3_latency", lat3, 32'd19);
        check("cs3_rsp", 32'(rsp_data3), 32'h0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
